bitstream_fifo: RTL and testbench

Parametrised byte-in, variable-width-out bit FIFO for the MP3 decoder front end. Byte-wide words from the frame reader are stored, and 1 to MAX_RD bits are extracted MSB-first per read, so side-info and Huffman logic can consume fields of any width in one cycle. It replaces the single-bit-per-read buffer and provides correct full/empty flags and bit-accurate occupancy.

---
 rtl/bitstream_fifo_pkg.sv | 30 +++
 rtl/bitstream_funnel.sv | 27 ++
 rtl/bitstream_fifo.sv | 149 ++++++++++++++
 tb/tb_bitstream_fifo.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_fifo_pkg.sv
// Shared constants and sizing helpers for the byte-in, variable-width-out bit FIFO.
package bitstream_fifo_pkg;

  localparam int unsigned IN_W_DEF   = 8;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned MAX_RD_DEF = 16;

  function automatic int unsigned rdb_w(input int unsigned max_rd);
    return $clog2(max_rd + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth, input int unsigned in_w);
    return $clog2(depth * in_w + 1);
  endfunction

  function automatic int unsigned off_w(input int unsigned in_w);
    return (in_w > 1) ? $clog2(in_w) : 1;
  endfunction

  function automatic bit params_ok(input int unsigned in_w, input int unsigned depth,
                                   input int unsigned max_rd);
    return (max_rd >= 1) && (max_rd <= 2 * in_w) && (depth >= 4) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/bitstream_funnel.sv
// Combinational extractor: pulls rd_bits bits MSB-first from a three-word window at a bit offset.
module bitstream_funnel
  import bitstream_fifo_pkg::*;
#(
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned MAX_RD = MAX_RD_DEF
) (
  input  logic [3*IN_W-1:0]         window_i,
  input  logic [off_w(IN_W)-1:0]    off_i,
  input  logic [rdb_w(MAX_RD)-1:0]  rd_bits_i,
  output logic [MAX_RD-1:0]         data_o
);

  localparam int unsigned WW  = 3 * IN_W;
  localparam int unsigned SHW = $clog2(WW + 1);

  logic [WW-1:0]  aligned_s;
  logic [WW-1:0]  justified_s;
  logic [SHW-1:0] rsh_s;

  // First unread bit is moved to the MSB, then the field is dropped down to bit 0.
  assign aligned_s   = window_i << off_i;
  assign rsh_s       = SHW'(WW) - SHW'(rd_bits_i);
  assign justified_s = aligned_s >> rsh_s;
  assign data_o      = justified_s[MAX_RD-1:0];

endmodule

// File: rtl/bitstream_fifo.sv
// Byte-in, 1..MAX_RD-bits-out FIFO for the MP3 front end.
// Optional BITSTREAM_FIFO_ALIGN_EN adds an align input that skips to the next word boundary.
module bitstream_fifo
  import bitstream_fifo_pkg::*;
#(
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned MAX_RD = MAX_RD_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr,
  input  logic [IN_W-1:0]                data_in,
  input  logic                           rd,
  input  logic [rdb_w(MAX_RD)-1:0]       rd_bits,
  output logic [MAX_RD-1:0]              data_out,
  output logic                           out_valid,
  output logic                           rd_err,
  output logic [cnt_w(DEPTH, IN_W)-1:0]  bit_count,
  output logic                           empty,
  output logic                           full
`ifdef BITSTREAM_FIFO_ALIGN_EN
  ,
  input  logic                           align
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned OW = off_w(IN_W);
  localparam int unsigned CW = cnt_w(DEPTH, IN_W);
  localparam int unsigned RW = rdb_w(MAX_RD);
  localparam int unsigned SW = $clog2(3 * IN_W);

  if (!params_ok(IN_W, DEPTH, MAX_RD)) begin : g_param_err
    $error("bitstream_fifo: illegal IN_W/DEPTH/MAX_RD combination");
  end

  logic [IN_W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     bit_off_q, bit_off_d;
  logic [CW-1:0]     bit_count_q, bit_count_d;
  logic [MAX_RD-1:0] data_out_q, data_out_d;
  logic              out_valid_q, rd_err_q, empty_q, full_q;
  logic              empty_d, full_d;

  logic              wr_acc_s, rd_ok_s, rd_acc_s, al_acc_s;
  logic [SW-1:0]     sum_s;
  logic [CW-1:0]     add_s, sub_s;
  logic [AW-1:0]     addr0_s;
  logic [3*IN_W-1:0] window_s;
  logic [MAX_RD-1:0] funnel_s;

  assign addr0_s  = rd_ptr_q[AW-1:0];
  assign window_s = {mem_q[addr0_s], mem_q[addr0_s + AW'(1)], mem_q[addr0_s + AW'(2)]};

  bitstream_funnel #(
    .IN_W   (IN_W),
    .MAX_RD (MAX_RD)
  ) u_funnel (
    .window_i  (window_s),
    .off_i     (bit_off_q),
    .rd_bits_i (rd_bits),
    .data_o    (funnel_s)
  );

  // Acceptance decisions and next-state for pointers, occupancy and output data.
  always_comb begin
    wr_acc_s = wr && !full_q;
    rd_ok_s  = (rd_bits != RW'(0)) && (rd_bits <= RW'(MAX_RD)) && (CW'(rd_bits) <= bit_count_q);
    rd_acc_s = rd && rd_ok_s;
`ifdef BITSTREAM_FIFO_ALIGN_EN
    al_acc_s = align && !rd && (bit_off_q != OW'(0));
`else
    al_acc_s = 1'b0;
`endif
    sum_s = SW'(bit_off_q) + SW'(rd_bits);

    wr_ptr_d   = wr_acc_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    bit_off_d  = bit_off_q;
    data_out_d = data_out_q;
    if (rd_acc_s) begin
      // Word boundaries crossed by the read retire whole words.
      rd_ptr_d   = rd_ptr_q + PW'(sum_s / SW'(IN_W));
      bit_off_d  = OW'(sum_s % SW'(IN_W));
      data_out_d = funnel_s;
    end else if (al_acc_s) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      bit_off_d = OW'(0);
    end else begin
      rd_ptr_d  = rd_ptr_q;
      bit_off_d = bit_off_q;
    end

    add_s = wr_acc_s ? CW'(IN_W) : CW'(0);
    if (rd_acc_s) begin
      sub_s = CW'(rd_bits);
    end else if (al_acc_s) begin
      sub_s = CW'(IN_W) - CW'(bit_off_q);
    end else begin
      sub_s = CW'(0);
    end
    bit_count_d = bit_count_q + add_s - sub_s;
    empty_d     = (bit_count_d == CW'(0));
    full_d      = ((wr_ptr_d - rd_ptr_d) == PW'(DEPTH));
  end

  // Word storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !rst) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

  // Pointer, occupancy and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= PW'(0);
      rd_ptr_q    <= PW'(0);
      bit_off_q   <= OW'(0);
      bit_count_q <= CW'(0);
      data_out_q  <= MAX_RD'(0);
      out_valid_q <= 1'b0;
      rd_err_q    <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      bit_off_q   <= bit_off_d;
      bit_count_q <= bit_count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= rd_acc_s;
      rd_err_q    <= rd && !rd_ok_s;
      empty_q     <= empty_d;
      full_q      <= full_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign rd_err    = rd_err_q;
  assign bit_count = bit_count_q;
  assign empty     = empty_q;
  assign full      = full_q;

endmodule

// File: tb/tb_bitstream_fifo.sv
// Randomised and directed bench for bitstream_fifo against a bit-queue reference model.
module tb_bitstream_fifo;

  localparam int IN_W   = 8;
  localparam int DEPTH  = 16;
  localparam int MAX_RD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [7:0]  data_in;
  logic        rd;
  logic [4:0]  rd_bits;
  logic [15:0] data_out;
  logic        out_valid;
  logic        rd_err;
  logic [7:0]  bit_count;
  logic        empty;
  logic        full;
  logic        align;

  bitstream_fifo #(.IN_W(IN_W), .DEPTH(DEPTH), .MAX_RD(MAX_RD)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .data_in   (data_in),
    .rd        (rd),
    .rd_bits   (rd_bits),
    .data_out  (data_out),
    .out_valid (out_valid),
    .rd_err    (rd_err),
    .bit_count (bit_count),
    .empty     (empty),
    .full      (full)
`ifdef BITSTREAM_FIFO_ALIGN_EN
    ,
    .align     (align)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: unread bits in order, plus word/bit totals for occupancy.
  bit          q[$];
  int          words_in;
  int          bits_out;
  logic [15:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int occupied_words();
    return words_in - bits_out / IN_W;
  endfunction

  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input int nb,
                       input logic a);
    int   off;
    logic wacc, rok, racc, aacc;
    bit   b;
    logic [15:0] v;
    wr = w; data_in = d; rd = r; rd_bits = 5'(nb); align = a;
    off  = bits_out % IN_W;
    rok  = (nb >= 1) && (nb <= MAX_RD) && (nb <= q.size());
    racc = r && rok;
`ifdef BITSTREAM_FIFO_ALIGN_EN
    aacc = a && !r && (off != 0);
`else
    aacc = a & 1'b0;
`endif
    wacc = w && (occupied_words() < DEPTH);
    if (racc) begin
      v = 16'h0;
      for (int i = 0; i < nb; i++) v = {v[14:0], q.pop_front()};
      exp_dout = v;
      bits_out += nb;
    end
    if (aacc) begin
      for (int i = 0; i < IN_W - off; i++) b = q.pop_front();
      bits_out += IN_W - off;
    end
    if (wacc) begin
      for (int i = IN_W - 1; i >= 0; i--) q.push_back(d[i]);
      words_in++;
    end
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; align = 1'b0; rd_bits = 5'd0;
    check("out_valid", {31'b0, out_valid}, {31'b0, racc});
    check("rd_err", {31'b0, rd_err}, {31'b0, r && !rok});
    check("data_out", {16'b0, data_out}, {16'b0, exp_dout});
    check("bit_count", {24'b0, bit_count}, q.size());
    check("empty", {31'b0, empty}, {31'b0, q.size() == 0});
    check("full", {31'b0, full}, {31'b0, occupied_words() == DEPTH});
  endtask

  task automatic do_reset(input logic rd_during);
    rst = 1'b1; wr = 1'b1; data_in = 8'h77; rd = rd_during; rd_bits = 5'd4; align = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; wr = 1'b0; rd = 1'b0; rd_bits = 5'd0;
    q.delete(); words_in = 0; bits_out = 0; exp_dout = 16'h0;
    check("rst_data_out", {16'b0, data_out}, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_rd_err", {31'b0, rd_err}, 32'h0);
    check("rst_bit_count", {24'b0, bit_count}, 32'h0);
    check("rst_empty", {31'b0, empty}, 32'h1);
    check("rst_full", {31'b0, full}, 32'h0);
  endtask

  initial begin
    int written;
    int base;
    int nb;
    int lim;
    logic w;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; data_in = 8'h0; rd_bits = 5'd0; align = 1'b0;
    words_in = 0; bits_out = 0; exp_dout = 16'h0;
    do_reset(1'b0);

    // Basic MSB-first extraction across a word boundary.
    cycle(1'b1, 8'hA5, 1'b0, 0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0, 0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 4, 1'b0);
    check("t1_rd4", {16'b0, data_out}, 32'hA);
    cycle(1'b0, 8'h00, 1'b1, 8, 1'b0);
    check("t1_rd8", {16'b0, data_out}, 32'h53);
    cycle(1'b0, 8'h00, 1'b1, 4, 1'b0);
    check("t1_rd4b", {16'b0, data_out}, 32'hC);
    check("t1_empty", {31'b0, empty}, 32'h1);

    // Fill to full, drop an extra write, then free a word.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i * 17 + 3), 1'b0, 0, 1'b0);
    check("t2_full", {31'b0, full}, 32'h1);
    check("t2_count", {24'b0, bit_count}, 32'd128);
    cycle(1'b1, 8'hEE, 1'b0, 0, 1'b0);
    check("t2_drop", {24'b0, bit_count}, 32'd128);
    cycle(1'b0, 8'h00, 1'b1, 8, 1'b0);
    check("t2_notfull", {31'b0, full}, 32'h0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 16, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 8, 1'b0);

    // Rejected reads with five bits held.
    cycle(1'b1, 8'h5A, 1'b0, 0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 3, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 6, 1'b0);
    check("t3_err6", {31'b0, rd_err}, 32'h1);
    check("t3_cnt5", {24'b0, bit_count}, 32'd5);
    cycle(1'b0, 8'h00, 1'b1, 0, 1'b0);
    check("t3_err0", {31'b0, rd_err}, 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 20, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 5, 1'b0);

    // Simultaneous write and read.
    cycle(1'b1, 8'hC3, 1'b0, 0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b1, 3, 1'b0);
    check("t4_cnt13", {24'b0, bit_count}, 32'd13);
    check("t4_valid", {31'b0, out_valid}, 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 13, 1'b0);

    // Random stream across pointer wrap.
    base = words_in; written = 0;
    for (int c = 0; c < 2000 && (written < 40 || q.size() > 0); c++) begin
      w  = (written < 40) && ($urandom % 3 != 0);
      nb = 0;
      if (q.size() > 0 && ($urandom % 2 == 0)) begin
        lim = (q.size() < MAX_RD) ? q.size() : MAX_RD;
        nb  = $urandom_range(lim, 1);
      end
      cycle(w, 8'($urandom), nb != 0, nb, 1'b0);
      written = words_in - base;
    end
    check("rand_written", written, 32'd40);
    check("rand_drained", {24'b0, bit_count}, 32'd0);

`ifdef BITSTREAM_FIFO_ALIGN_EN
    do_reset(1'b0);
    cycle(1'b1, 8'hF0, 1'b0, 0, 1'b0);
    cycle(1'b1, 8'h81, 1'b0, 0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 3, 1'b0);
    check("al_cnt13", {24'b0, bit_count}, 32'd13);
    cycle(1'b0, 8'h00, 1'b0, 0, 1'b1);
    check("al_cnt8", {24'b0, bit_count}, 32'd8);
    check("al_novalid", {31'b0, out_valid}, 32'h0);
    cycle(1'b0, 8'h00, 1'b0, 0, 1'b1);
    check("al_nop", {24'b0, bit_count}, 32'd8);
    cycle(1'b0, 8'h00, 1'b1, 8, 1'b0);
    check("al_rd8", {16'b0, data_out}, 32'h81);
`endif

    // Reset in the middle of traffic, with a read pending.
    cycle(1'b1, 8'h96, 1'b0, 0, 1'b0);
    cycle(1'b1, 8'h69, 1'b1, 5, 1'b0);
    do_reset(1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
